wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
- Washing-machine program sequencer; the initiator side of the timer interface (drives `timer_rst`/`timer_en`/`timer_clk_freq`/`timer_period`, consumes `timer_done`).
- Steps FILL -> WASH -> RINSE -> SPIN -> COMPLETE, each phase length set by a parameter in seconds.
- Drives valve/motor/drain actuators and supports lid-open pause plus abort.
- Sits between the front panel and the shared timer instance.

Parameters:
- CLK_FREQ, 5, ticks per second; driven constantly onto `timer_clk_freq`
- FILL_SEC, 2, fill phase duration (s), 1..65535
- WASH_SEC, 5, wash phase duration (s), 1..65535
- RINSE_SEC, 3, rinse phase duration (s), 1..65535
- SPIN_SEC, 4, spin phase duration (s), 1..65535

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a program
- stop  in  1  abort request, level
- lid_closed  in  1  1 = lid closed
- timer_done  in  1  timer expiry, level, cleared by `timer_rst`
- timer_rst  out  1  timer restart strobe
- timer_en  out  1  timer count enable
- timer_clk_freq  out  16  = CLK_FREQ
- timer_period  out  16  duration of current phase (s)
- water_valve  out  1  inlet valve
- motor_on  out  1  drum agitate
- spin_on  out  1  high-speed spin
- drain  out  1  drain pump
- paused  out  1  timed phase held by open lid
- cycle_done  out  1  one-cycle pulse at program end
- phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 COMPLETE

Behaviour:
- Reset (async, any state): state IDLE.
  - All outputs 0 except `timer_clk_freq` = CLK_FREQ and `timer_period` = 0.
  - `phase` = 0.
- All outputs registered or decoded from registered state and the first-cycle flag only. No combinational path from `timer_done` to any output.
- IDLE: `start` = 1 and `lid_closed` = 1 and `stop` = 0 -> FILL next cycle. `start` with lid open is ignored; it is not remembered.
- Phase entry, every timed phase:
  - First cycle in the phase: `timer_rst` = 1, `timer_en` = 0, `timer_period` = phase SEC.
  - `timer_done` is ignored in that cycle.
  - Following cycles: `timer_rst` = 0, `timer_en` = `lid_closed`.
  - `timer_period` holds for the whole phase.
- Advance: `timer_done` sampled 1 in a non-first cycle of a phase, with no pause active -> next phase at that edge.
- Order: FILL -> WASH -> RINSE -> SPIN -> COMPLETE -> IDLE.
- Phase timing against a bench timer model:
  - Model: count cleared on `timer_rst`, +1 per `timer_en` cycle, `timer_done` = (count >= freq*period) combinational.
  - Each phase occupies exactly CLK_FREQ*SEC + 2 cycles.
- Actuators by phase, all gated by `lid_closed`:
  - FILL: `water_valve`.
  - WASH: `motor_on`.
  - RINSE: `water_valve` and `motor_on`.
  - SPIN: `drain` and `spin_on`.
- Pause (timed phase, `lid_closed` = 0):
  - `paused` = 1, `timer_en` = 0, actuators 0, state and timer count held.
  - Lid closes again: resume same phase with no timer restart.
  - Lid opening in the first cycle of a phase delays nothing except the count.
- COMPLETE: lasts exactly 1 cycle. `cycle_done` = 1 and `drain` = 1, then IDLE.
- `stop` = 1 in any non-IDLE state:
  - Next cycle IDLE, actuators 0.
  - `timer_rst` = 1 for that one cycle.
  - No `cycle_done`.
  - `stop` has priority over `timer_done` advance and over pause.
- `start` while not IDLE: ignored.
- Simultaneous `start` and `stop` in IDLE: stay IDLE.
- `timer_done` already high on a phase's first cycle (stale from the previous phase): ignored, because `timer_rst` clears it.

Test Plan:
- Nominal run (CLK_FREQ=2, FILL=1, WASH=2, RINSE=1, SPIN=1), bench timer model, `start` pulse with lid closed:
  - FILL 4, WASH 6, RINSE 4, SPIN 4 cycles, then COMPLETE 1 cycle.
  - `cycle_done` pulses exactly once, 19 cycles after FILL entry.
  - `timer_period` sequence is 1, 2, 1, 1.
- Pause: lid opened 3 cycles mid-WASH:
  - `paused` = 1 and `motor_on` = 0 for those 3 cycles.
  - WASH lasts 9 cycles total.
  - No `timer_rst` at resume.
- Abort: `stop` pulsed in RINSE -> next cycle `phase` = 0, `timer_rst` = 1 for one cycle, all actuators 0, `cycle_done` never asserted.
- Start guards, each of these leaves the block in IDLE with no `timer_rst`:
  - `start` with `lid_closed` = 0.
  - `start` together with `stop`.
  - `start` pulsed during SPIN (no effect).
- Async reset asserted mid-FILL between clock edges: outputs 0 immediately, without waiting for a clock edge. Release reset, then `start` -> normal FILL entry.
- Stale done: bench holds `timer_done` = 1 on a phase's first cycle -> no advance; phase still lasts CLK_FREQ*SEC + 2 cycles.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program sequencer: steps FILL/WASH/RINSE/SPIN/COMPLETE,
// drives the shared phase timer and gates the actuators on the lid switch.
module wash_cycle_ctrl #(
    parameter int CLK_FREQ  = 5,
    parameter int FILL_SEC  = 2,
    parameter int WASH_SEC  = 5,
    parameter int RINSE_SEC = 3,
    parameter int SPIN_SEC  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        lid_closed,
    input  logic        timer_done,
    output logic        timer_rst,
    output logic        timer_en,
    output logic [15:0] timer_clk_freq,
    output logic [15:0] timer_period,
    output logic        water_valve,
    output logic        motor_on,
    output logic        spin_on,
    output logic        drain,
    output logic        paused,
    output logic        cycle_done,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WASH     = 3'd2,
        ST_RINSE    = 3'd3,
        ST_SPIN     = 3'd4,
        ST_COMPLETE = 3'd5
    } state_e;

    state_e      state_q, state_d, next_s;
    logic        first_q, first_d;
    logic        trst_q, trst_d;
    logic [15:0] period_q, period_d;
    logic        valve_q, valve_d;
    logic        motor_q, motor_d;
    logic        spin_q, spin_d;
    logic        drain_q, drain_d;
    logic        done_q, done_d;
    logic        timed_s;

    function automatic state_e next_phase(input state_e st);
        case (st)
            ST_FILL:  next_phase = ST_WASH;
            ST_WASH:  next_phase = ST_RINSE;
            ST_RINSE: next_phase = ST_SPIN;
            ST_SPIN:  next_phase = ST_COMPLETE;
            default:  next_phase = ST_IDLE;
        endcase
    endfunction

    function automatic logic [15:0] phase_period(input state_e st);
        case (st)
            ST_FILL:  phase_period = 16'(FILL_SEC);
            ST_WASH:  phase_period = 16'(WASH_SEC);
            ST_RINSE: phase_period = 16'(RINSE_SEC);
            ST_SPIN:  phase_period = 16'(SPIN_SEC);
            default:  phase_period = 16'd0;
        endcase
    endfunction

    assign timed_s = (state_q == ST_FILL) || (state_q == ST_WASH) ||
                     (state_q == ST_RINSE) || (state_q == ST_SPIN);
    assign next_s  = next_phase(state_q);

    // Next-state logic; the first cycle of a phase never advances, so a stale done is ignored.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        trst_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && lid_closed && !stop) begin
                    state_d = ST_FILL;
                    first_d = 1'b1;
                    trst_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    trst_d  = 1'b1;
                end else if (!first_q && timer_done && lid_closed) begin
                    state_d = next_s;
                    first_d = (next_s != ST_COMPLETE);
                    trst_d  = (next_s != ST_COMPLETE);
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
                trst_d  = stop;
            end
            default: begin
                state_d = ST_IDLE;
                trst_d  = 1'b1;
            end
        endcase
        valve_d  = (state_d == ST_FILL) || (state_d == ST_RINSE);
        motor_d  = (state_d == ST_WASH) || (state_d == ST_RINSE);
        spin_d   = (state_d == ST_SPIN);
        drain_d  = (state_d == ST_SPIN);
        done_d   = (state_d == ST_COMPLETE);
        period_d = phase_period(state_d);
    end

    // State register with per-phase outputs registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            first_q  <= 1'b0;
            trst_q   <= 1'b0;
            period_q <= 16'd0;
            valve_q  <= 1'b0;
            motor_q  <= 1'b0;
            spin_q   <= 1'b0;
            drain_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            trst_q   <= trst_d;
            period_q <= period_d;
            valve_q  <= valve_d;
            motor_q  <= motor_d;
            spin_q   <= spin_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
        end
    end

    // An open lid silences actuators and freezes the count; COMPLETE drains regardless.
    assign timer_rst      = trst_q;
    assign timer_en       = timed_s && !first_q && lid_closed;
    assign timer_clk_freq = 16'(CLK_FREQ);
    assign timer_period   = period_q;
    assign water_valve    = valve_q && lid_closed;
    assign motor_on       = motor_q && lid_closed;
    assign spin_on        = spin_q && lid_closed;
    assign drain          = (drain_q && lid_closed) || done_q;
    assign paused         = timed_s && !lid_closed;
    assign cycle_done     = done_q;
    assign phase          = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl with a behavioural timer model.
module tb_wash_cycle_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        lid_closed;
    logic        timer_done;
    logic        timer_rst;
    logic        timer_en;
    logic [15:0] timer_clk_freq;
    logic [15:0] timer_period;
    logic        water_valve;
    logic        motor_on;
    logic        spin_on;
    logic        drain;
    logic        paused;
    logic        cycle_done;
    logic [2:0]  phase;

    wash_cycle_ctrl #(
        .CLK_FREQ(2), .FILL_SEC(1), .WASH_SEC(2), .RINSE_SEC(1), .SPIN_SEC(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .lid_closed(lid_closed), .timer_done(timer_done),
        .timer_rst(timer_rst), .timer_en(timer_en),
        .timer_clk_freq(timer_clk_freq), .timer_period(timer_period),
        .water_valve(water_valve), .motor_on(motor_on), .spin_on(spin_on),
        .drain(drain), .paused(paused), .cycle_done(cycle_done), .phase(phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timer model: cleared by timer_rst, counts enabled cycles, done is combinational.
    logic [31:0] tcount;
    logic        stale_force;
    always @(posedge clk) begin
        if (reset || timer_rst) tcount <= 32'd0;
        else if (timer_en)      tcount <= tcount + 32'd1;
    end
    assign timer_done = (tcount >= (32'(timer_clk_freq) * 32'(timer_period))) || stale_force;

    logic [10:0] outs_s;
    assign outs_s = {phase, timer_rst, timer_en, water_valve, motor_on, spin_on,
                     drain, paused, cycle_done};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic        start;
        logic        stop;
        logic        lid;
        logic [10:0] exp_outs;
        logic [15:0] exp_period;
    } vec_t;

    vec_t vecs[14];

    int          len[8];
    logic [15:0] periods[$];
    int          done_cnt, done_at, idle_rst, wash_seen, wash_rst, pause_cnt, rinse_seen, abort_k;
    logic        spin_start_done;

    initial begin
        // outputs: phase(3) trst ten valve motor spin drain paused cdone
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 11'b000_00000000, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 11'b000_00000000, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 11'b000_00000000, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 11'b000_00000000, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 11'b000_00000000, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 11'b001_10100000, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 11'b001_01100000, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 11'b001_00000010, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 11'b001_01100000, 16'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 11'b001_01100000, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 11'b010_10010000, 16'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 11'b010_00000010, 16'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 11'b000_10000000, 16'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 11'b000_00000000, 16'd0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; lid_closed = 1'b1; stale_force = 1'b0;
        @(negedge clk); #1;
        check("reset outs", 32'(outs_s), 32'd0);
        check("reset period", 32'(timer_period), 32'd0);
        check("reset freq", 32'(timer_clk_freq), 32'd2);
        @(negedge clk);
        reset = 1'b0;

        // Table: start guards, FILL with a lid pause, abort from a paused WASH
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; lid_closed = vecs[i].lid;
            #1;
            check($sformatf("vec%0d outs", i), 32'(outs_s), 32'(vecs[i].exp_outs));
            check($sformatf("vec%0d period", i), 32'(timer_period), 32'(vecs[i].exp_period));
        end
        start = 1'b0; stop = 1'b0; lid_closed = 1'b1;

        // Nominal run with a forced stale done on SPIN entry and a start pulse in SPIN
        for (int p = 0; p < 8; p++) len[p] = 0;
        done_cnt = 0; done_at = -1; idle_rst = 0; spin_start_done = 1'b0;
        @(negedge clk); start = 1'b1; #1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            stale_force = (phase == 3'd4) && timer_rst;
            if (phase == 3'd4 && !timer_rst && !spin_start_done) begin
                start = 1'b1;
                spin_start_done = 1'b1;
            end
            #1;
            len[phase]++;
            if (timer_rst && phase != 3'd0) periods.push_back(timer_period);
            if (cycle_done) begin done_cnt++; done_at = k; end
            if (phase == 3'd0 && timer_rst) idle_rst++;
        end
        start = 1'b0; stale_force = 1'b0;
        check("nom fill len", 32'(len[1]), 32'd4);
        check("nom wash len", 32'(len[2]), 32'd6);
        check("nom rinse len", 32'(len[3]), 32'd4);
        check("nom spin len", 32'(len[4]), 32'd4);
        check("nom complete len", 32'(len[5]), 32'd1);
        check("nom done count", 32'(done_cnt), 32'd1);
        check("nom done cycle", 32'(done_at), 32'd19);
        check("nom period count", 32'(periods.size()), 32'd4);
        if (periods.size() == 4) begin
            check("nom period0", 32'(periods[0]), 32'd1);
            check("nom period1", 32'(periods[1]), 32'd2);
            check("nom period2", 32'(periods[2]), 32'd1);
            check("nom period3", 32'(periods[3]), 32'd1);
        end
        check("nom end phase", 32'(phase), 32'd0);
        check("nom idle rst", 32'(idle_rst), 32'd0);

        // Lid opened for three cycles in the middle of WASH
        wash_seen = 0; wash_rst = 0; pause_cnt = 0; done_cnt = 0;
        @(negedge clk); start = 1'b1; #1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (phase == 3'd2) wash_seen++;
            lid_closed = !(phase == 3'd2 && wash_seen >= 3 && wash_seen <= 5);
            #1;
            if (phase == 3'd2 && !lid_closed) begin
                pause_cnt++;
                check("pause paused", 32'(paused), 32'd1);
                check("pause motor", 32'(motor_on), 32'd0);
                check("pause en", 32'(timer_en), 32'd0);
            end
            if (phase == 3'd2 && timer_rst) wash_rst++;
            if (cycle_done) done_cnt++;
        end
        lid_closed = 1'b1;
        check("pause cycles", 32'(pause_cnt), 32'd3);
        check("pause wash len", 32'(wash_seen), 32'd9);
        check("pause wash rst", 32'(wash_rst), 32'd1);
        check("pause done count", 32'(done_cnt), 32'd1);

        // Abort from RINSE
        rinse_seen = 0; abort_k = -10; done_cnt = 0;
        @(negedge clk); start = 1'b1; #1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            if (phase == 3'd3) rinse_seen++;
            if (phase == 3'd3 && rinse_seen == 2) begin
                stop = 1'b1;
                abort_k = k;
            end
            #1;
            if (k == abort_k + 1) begin
                check("abort outs", 32'(outs_s), 32'(11'b000_10000000));
                check("abort period", 32'(timer_period), 32'd0);
            end
            if (k == abort_k + 2) check("abort after outs", 32'(outs_s), 32'd0);
            if (cycle_done) done_cnt++;
        end
        stop = 1'b0;
        check("abort reached", 32'(abort_k > 0), 32'd1);
        check("abort no done", 32'(done_cnt), 32'd0);

        // Asynchronous reset between edges in FILL, then a clean restart
        @(negedge clk); start = 1'b1; #1;
        @(negedge clk); start = 1'b0; #1;
        @(negedge clk); #1;
        check("pre-reset valve", 32'(water_valve), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset outs", 32'(outs_s), 32'd0);
        check("async reset period", 32'(timer_period), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); start = 1'b1; #1;
        check("restart idle outs", 32'(outs_s), 32'd0);
        @(negedge clk); start = 1'b0; #1;
        check("restart fill outs", 32'(outs_s), 32'(11'b001_10100000));
        check("restart fill period", 32'(timer_period), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
